ds3_frame_sync: RTL and testbench
=================================

Name: ds3_frame_sync

Overview:
Receive-side frame alignment stage for the G.752 DS3 serial path, fed by the bit stream from the framing/FAW-insertion stage.
- Hunts for the frame alignment word (FAW) in the serial input.
- Confirms alignment over consecutive frames, then declares sync.
- Flags FAW errors and drops sync after repeated misses.
- In sync, outputs frame pulses and the payload bits (FAW stripped) to the downstream demultiplexer.

Parameters:
FRAME_LEN, 200, bits per frame including FAW (counter range 0..FRAME_LEN-1)
FAW_WIDTH, 8, FAW length in bits, occupying frame bit positions 0..FAW_WIDTH-1
FAW, 8'b10011001, alignment word, MSB received first
CONFIRM_N, 3, consecutive FAW matches (including the first detection) required to enter SYNC
LOSS_N, 4, consecutive FAW misses in SYNC that force return to HUNT

Ports:
clk  in  1  bit clock, all logic on posedge
reset  in  1  synchronous reset, active-low: reset==0 at posedge clears all state
in  in  1  serial data bit
in_en  in  1  qualifies in; bit accepted only when 1
in_sync  out  1  1 while state==SYNC
frame_pulse  out  1  one-cycle pulse: last FAW bit accepted and matched while in SYNC or on the SYNC-entering match
faw_err  out  1  one-cycle pulse: FAW mismatch checked while in SYNC
data_out  out  1  registered payload bit
data_valid  out  1  data_out is a payload bit
bit_pos  out  $clog2(FRAME_LEN)  index of next expected bit; meaningful outside HUNT
miss_cnt  out  $clog2(LOSS_N+1)  consecutive misses in SYNC

Behaviour:
- Reset (reset==0): state=HUNT. Clear shift register, bit_pos, hit counter, miss_cnt. All outputs 0.
- in_en==0: no register changes except the pulses; frame_pulse, faw_err and data_valid are driven 0.
- Window w = {sr[FAW_WIDTH-2:0], in}, the current bit plus the previous FAW_WIDTH-1 bits. sr shifts in `in` on every accepted bit, in all states.
- HUNT:
  - Position-free search.
  - On w==FAW: go to PRESYNC, hits=1, bit_pos=FAW_WIDTH.
  - If CONFIRM_N==1: go directly to SYNC and assert frame_pulse.
- Counting (PRESYNC, SYNC): each accepted bit advances bit_pos by 1, wrapping FRAME_LEN-1 -> 0. The check point is the cycle the accepted bit has index FAW_WIDTH-1.
- PRESYNC check point:
  - Match: hits++.
  - If hits reaches CONFIRM_N: go to SYNC, assert frame_pulse, set miss_cnt=0.
  - Mismatch: go to HUNT, hits=0. Hunting resumes with the next accepted bit; the current window is not re-examined.
- SYNC check point:
  - Match: frame_pulse=1, miss_cnt=0.
  - Mismatch: faw_err=1, miss_cnt++.
  - If miss_cnt reaches LOSS_N: go to HUNT, in_sync drops the next cycle, miss_cnt cleared.
  - No FAW check outside the check point. bit_pos keeps counting through misses.
- Payload:
  - In SYNC, an accepted bit with index >= FAW_WIDTH is registered to data_out with data_valid=1. Latency 1 clk.
  - FAW bits never produce data_valid.
  - No payload is output in HUNT or PRESYNC. On the transition into SYNC, the first valid payload bit is index FAW_WIDTH of that same frame.
- Timing of outputs: in_sync, frame_pulse, faw_err and data_valid are registered, so all change 1 clk after the deciding accepted bit.
- Reset mid-operation: reset overrides in_en and state. Any pulse pending in that cycle is suppressed.
- Emulated FAW in payload during HUNT is accepted as a candidate; PRESYNC rejects it at the next check point.

Decomposition:
- Package ds3_pkg holds:
  - state enum {HUNT, PRESYNC, SYNC}
  - FAW constant and FAW_WIDTH
  - DS3 FRAME_LEN default
- One sub-module, ds3_faw_detect: shift register plus comparator. Inputs clk, reset, in, in_en; output match (combinational on w).
- Counters and state machine stay in ds3_frame_sync.

Test Plan:
- Clean stream, FAW every 200 bits, random payload, in_en=1 -> in_sync rises 1 clk after the 3rd FAW's last bit. frame_pulse at that point and every 200 bits after. data_valid on exactly 192 bits per frame, each equal to the input delayed 1 clk.
- In SYNC, corrupt one FAW (10011000) -> faw_err pulse, miss_cnt=1, in_sync stays 1. Next good FAW -> miss_cnt=0, frame_pulse.
- In SYNC, corrupt 4 consecutive FAWs -> faw_err x4. in_sync falls 1 clk after the 4th check. Re-sync after 3 good FAWs.
- During HUNT, place 10011001 in the payload 50 bits before the true FAW -> PRESYNC entered. Mismatch at the next check returns to HUNT. Final lock on the true FAW with correct bit_pos.
- Random in_en gaps (~30% low) on a clean stream -> identical sync timing measured in accepted bits. No output pulses on in_en=0 cycles.
- Assert reset=0 for 1 clk mid-SYNC -> all outputs 0 next cycle, state HUNT. Relock after 3 frames.

Source files
------------

// File: rtl/ds3_pkg.sv
// Shared types and constants for the DS3 receive frame alignment slice.
package ds3_pkg;

  // Alignment state: searching, confirming a candidate, locked.
  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PRESYNC = 2'd1,
    SYNC    = 2'd2
  } ds3_state_t;

  // Frame alignment word, MSB is the first bit on the line.
  localparam int                   FAW_WIDTH = 8;
  localparam logic [FAW_WIDTH-1:0] FAW       = 8'b10011001;

  // G.752 DS3 frame length and default lock/loss thresholds.
  localparam int DS3_FRAME_LEN = 200;
  localparam int DS3_CONFIRM_N = 3;
  localparam int DS3_LOSS_N    = 4;

endpackage

// File: rtl/ds3_faw_detect.sv
// Serial FAW detector: keeps the last FAW_WIDTH-1 accepted bits and compares
// them, together with the current bit, against the alignment word.
module ds3_faw_detect
  import ds3_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in,
  input  logic in_en,
  output logic match
);

  logic [FAW_WIDTH-2:0] sr;
  logic [FAW_WIDTH-1:0] w;
  logic [FAW_WIDTH-1:0] bit_eq;

  // Window is the current bit appended to the stored history (newest in LSB).
  assign w = {sr, in};

  // History register advances only on accepted bits, in every alignment state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr <= '0;
    end else if (in_en) begin
      sr <= w[FAW_WIDTH-2:0];
    end
  end

  // Bitwise equality against the alignment word, reduced to a single match.
  genvar gi;
  generate
    for (gi = 0; gi < FAW_WIDTH; gi++) begin : g_cmp
      assign bit_eq[gi] = (w[gi] == FAW[gi]);
    end
  endgenerate

  assign match = &bit_eq;

endmodule

// File: rtl/ds3_frame_sync.sv
// DS3 receive frame alignment: hunts for the FAW, confirms it over several
// frames, declares sync, tracks misses and strips the FAW from the payload.
module ds3_frame_sync
  import ds3_pkg::*;
#(
  parameter int FRAME_LEN = DS3_FRAME_LEN,
  parameter int CONFIRM_N = DS3_CONFIRM_N,
  parameter int LOSS_N    = DS3_LOSS_N
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in,
  input  logic                           in_en,
  output logic                           in_sync,
  output logic                           frame_pulse,
  output logic                           faw_err,
  output logic                           data_out,
  output logic                           data_valid,
  output logic [$clog2(FRAME_LEN)-1:0]   bit_pos,
  output logic [$clog2(LOSS_N+1)-1:0]    miss_cnt
);

  localparam int POS_W  = $clog2(FRAME_LEN);
  localparam int MISS_W = $clog2(LOSS_N + 1);
  localparam int HIT_W  = $clog2(CONFIRM_N + 1);

  localparam logic [POS_W-1:0]  POS_LAST    = POS_W'(FRAME_LEN - 1);
  localparam logic [POS_W-1:0]  POS_CHECK   = POS_W'(FAW_WIDTH - 1);
  localparam logic [POS_W-1:0]  POS_PAYLOAD = POS_W'(FAW_WIDTH);
  localparam logic [HIT_W-1:0]  HITS_LAST   = HIT_W'(CONFIRM_N - 1);
  localparam logic [MISS_W-1:0] MISS_LAST   = MISS_W'(LOSS_N - 1);

  ds3_state_t       state;
  logic [HIT_W-1:0] hits;
  logic             match;
  logic [POS_W-1:0] pos_next;
  logic             at_check;

  ds3_faw_detect u_faw_detect (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .in_en (in_en),
    .match (match)
  );

  // bit_pos names the index of the bit about to arrive, so the bit being
  // accepted right now carries index bit_pos.
  assign pos_next = (bit_pos == POS_LAST) ? '0 : bit_pos + POS_W'(1);
  assign at_check = (bit_pos == POS_CHECK);

  // Alignment state machine with position/hit/miss counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= HUNT;
      hits        <= '0;
      bit_pos     <= '0;
      miss_cnt    <= '0;
      in_sync     <= 1'b0;
      frame_pulse <= 1'b0;
      faw_err     <= 1'b0;
      data_out    <= 1'b0;
      data_valid  <= 1'b0;
    end else begin
      frame_pulse <= 1'b0;
      faw_err     <= 1'b0;
      data_valid  <= 1'b0;
      if (in_en) begin
        case (state)
          HUNT: begin
            // Position-free search; a hit fixes the frame phase.
            if (match) begin
              bit_pos <= POS_PAYLOAD;
              if (CONFIRM_N == 1) begin
                state       <= SYNC;
                in_sync     <= 1'b1;
                frame_pulse <= 1'b1;
                miss_cnt    <= '0;
                hits        <= '0;
              end else begin
                state <= PRESYNC;
                hits  <= HIT_W'(1);
              end
            end
          end

          PRESYNC: begin
            bit_pos <= pos_next;
            if (at_check) begin
              if (match) begin
                if (hits == HITS_LAST) begin
                  state       <= SYNC;
                  in_sync     <= 1'b1;
                  frame_pulse <= 1'b1;
                  miss_cnt    <= '0;
                  hits        <= '0;
                end else begin
                  hits <= hits + HIT_W'(1);
                end
              end else begin
                // Candidate was payload emulating the FAW; resume hunting
                // from the next bit.
                state <= HUNT;
                hits  <= '0;
              end
            end
          end

          SYNC: begin
            bit_pos <= pos_next;
            if (bit_pos >= POS_PAYLOAD) begin
              data_out   <= in;
              data_valid <= 1'b1;
            end
            if (at_check) begin
              if (match) begin
                frame_pulse <= 1'b1;
                miss_cnt    <= '0;
              end else begin
                faw_err <= 1'b1;
                if (miss_cnt == MISS_LAST) begin
                  state    <= HUNT;
                  in_sync  <= 1'b0;
                  miss_cnt <= '0;
                end else begin
                  miss_cnt <= miss_cnt + MISS_W'(1);
                end
              end
            end
          end

          default: begin
            state   <= HUNT;
            in_sync <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ds3_frame_sync.sv
// Self-checking bench for ds3_frame_sync: a frame-phase model tracks the
// accepted bit stream and a negedge process compares every output each cycle.
module tb_ds3_frame_sync;

  localparam logic [7:0] TB_FAW = 8'b10011001;
  localparam logic [7:0] TB_BAD = 8'b10011000;
  localparam int         FLEN   = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       din = 1'b0;
  logic       din_en = 1'b0;
  logic       in_sync, frame_pulse, faw_err, data_out, data_valid;
  logic [7:0] bit_pos;
  logic [2:0] miss_cnt;

  int checks = 0;
  int failures = 0;

  ds3_frame_sync dut (
    .clk         (clk),
    .reset       (reset),
    .in          (din),
    .in_en       (din_en),
    .in_sync     (in_sync),
    .frame_pulse (frame_pulse),
    .faw_err     (faw_err),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .bit_pos     (bit_pos),
    .miss_cnt    (miss_cnt)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model remembers the accepted-bit number (anchor) at which the current
  // frame phase was found; the frame index of any later bit follows from
  // modular distance to that anchor.
  int  m_k = 0, m_win = 0, m_mode = 0, m_anchor = 0, m_hits = 0, m_miss = 0;
  bit  m_ready = 0;
  bit  e_sync = 0, e_fp = 0, e_fe = 0, e_dv = 0, e_do = 0, e_pos_ok = 0;
  int  e_pos = 0;

  always @(posedge clk) begin
    int idx;
    bit ok;
    if (!reset) begin
      m_k = 0; m_win = 0; m_mode = 0; m_anchor = 0; m_hits = 0; m_miss = 0;
      e_fp = 0; e_fe = 0; e_dv = 0; e_do = 0; e_pos = 0;
      m_ready = 1;
    end else begin
      e_fp = 0; e_fe = 0; e_dv = 0;
      if (din_en) begin
        m_win = ((m_win << 1) | int'(din)) & 255;
        if (m_mode == 0) begin
          if (m_win == int'(TB_FAW)) begin
            m_mode = 1; m_anchor = m_k; m_hits = 1; e_pos = 8;
          end
        end else begin
          idx   = (m_k - m_anchor + 7) % FLEN;
          e_pos = (idx + 1) % FLEN;
          if (m_mode == 2 && idx >= 8) begin
            e_dv = 1; e_do = din;
          end
          if (idx == 7) begin
            ok = (m_win == int'(TB_FAW));
            if (m_mode == 1) begin
              if (ok) begin
                m_hits++;
                if (m_hits == 3) begin m_mode = 2; e_fp = 1; m_miss = 0; end
              end else begin
                m_mode = 0; m_hits = 0;
              end
            end else begin
              if (ok) begin
                e_fp = 1; m_miss = 0;
              end else begin
                e_fe = 1; m_miss++;
                if (m_miss == 4) begin m_mode = 0; m_miss = 0; end
              end
            end
          end
        end
        m_k++;
      end
    end
    e_sync   = (m_mode == 2);
    e_pos_ok = (m_mode != 0);
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_ready) begin
      check("in_sync", int'(in_sync), int'(e_sync));
      check("frame_pulse", int'(frame_pulse), int'(e_fp));
      check("faw_err", int'(faw_err), int'(e_fe));
      check("data_valid", int'(data_valid), int'(e_dv));
      check("miss_cnt", int'(miss_cnt), m_miss);
      if (e_dv) check("data_out", int'(data_out), int'(e_do));
      if (e_pos_ok) check("bit_pos", int'(bit_pos), e_pos);
    end
  end

  // ---------------- stimulus helpers ----------------
  int acc_cnt = 0, rise_acc = -1, rise_pos = -1, tb_win = 0;
  int fp_cnt = 0, fe_cnt = 0, dv_cnt = 0, idle_pulses = 0;
  bit rose = 0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b, input int gap);
    while ($urandom_range(99) < gap) begin
      din = 1'($urandom); din_en = 1'b0;
      step();
      if (frame_pulse || faw_err || data_valid) idle_pulses++;
    end
    din = b; din_en = 1'b1;
    step();
    acc_cnt++;
    tb_win = ((tb_win << 1) | int'(b)) & 255;
    if (frame_pulse) fp_cnt++;
    if (faw_err) fe_cnt++;
    if (data_valid) dv_cnt++;
    if (!rose && in_sync) begin
      rose = 1; rise_acc = acc_cnt; rise_pos = int'(bit_pos);
    end
  endtask

  // One frame: given FAW then random payload that never forms the FAW in any
  // window, with a zero tail so no window straddling the next FAW matches.
  task automatic send_frame(input logic [7:0] faw, input int gap);
    logic b;
    for (int i = 0; i < 8; i++) send_bit(faw[7-i], gap);
    for (int i = 8; i < FLEN; i++) begin
      b = (i >= FLEN - 8) ? 1'b0 : 1'($urandom);
      if ((((tb_win << 1) | int'(b)) & 255) == int'(TB_FAW)) b = ~b;
      send_bit(b, gap);
    end
  endtask

  task automatic clear_counts();
    fp_cnt = 0; fe_cnt = 0; dv_cnt = 0; idle_pulses = 0;
    acc_cnt = 0; rose = 0; rise_acc = -1; rise_pos = -1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_sync"}, int'(in_sync), 0);
    check({tag, "_frame_pulse"}, int'(frame_pulse), 0);
    check({tag, "_faw_err"}, int'(faw_err), 0);
    check({tag, "_data_valid"}, int'(data_valid), 0);
    check({tag, "_data_out"}, int'(data_out), 0);
    check({tag, "_bit_pos"}, int'(bit_pos), 0);
    check({tag, "_miss_cnt"}, int'(miss_cnt), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0; din = 1'b1; din_en = 1'b1;
    step();
    reset = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] faw_v;
    faw_v = TB_FAW;

    reset = 1'b0; din = 1'b0; din_en = 1'b0;
    repeat (3) step();
    check_all_zero("rst");
    reset = 1'b1;

    // Clean stream: lock after the 3rd FAW, then a full frame in SYNC.
    clear_counts();
    repeat (3) send_frame(TB_FAW, 0);
    check("t1_rise_acc", rise_acc, 408);
    check("t1_rise_pos", rise_pos, 8);
    clear_counts();
    send_frame(TB_FAW, 0);
    check("t1_dv_per_frame", dv_cnt, 192);
    check("t1_fp_per_frame", fp_cnt, 1);
    check("t1_fe_per_frame", fe_cnt, 0);

    // Single corrupted FAW, then recovery.
    clear_counts();
    send_frame(TB_BAD, 0);
    check("t2_faw_err", fe_cnt, 1);
    check("t2_miss_cnt", int'(miss_cnt), 1);
    check("t2_in_sync", int'(in_sync), 1);
    clear_counts();
    send_frame(TB_FAW, 0);
    check("t2_miss_clr", int'(miss_cnt), 0);
    check("t2_fp", fp_cnt, 1);

    // Four consecutive misses drop sync; three good frames relock.
    clear_counts();
    repeat (3) send_frame(TB_BAD, 0);
    check("t3_miss3", int'(miss_cnt), 3);
    check("t3_sync_held", int'(in_sync), 1);
    send_frame(TB_BAD, 0);
    check("t3_faw_err4", fe_cnt, 4);
    check("t3_sync_lost", int'(in_sync), 0);
    check("t3_miss_clr", int'(miss_cnt), 0);
    repeat (2) send_frame(TB_FAW, 0);
    check("t3_not_yet", int'(in_sync), 0);
    send_frame(TB_FAW, 0);
    check("t3_relock", int'(in_sync), 1);

    // Emulated FAW 50 bits before the true FAW while hunting.
    pulse_reset();
    clear_counts();
    for (int i = 0; i < 142; i++) send_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) send_bit(faw_v[7-i], 0);
    check("t4_presync_pos", int'(bit_pos), 8);
    check("t4_presync_nosync", int'(in_sync), 0);
    for (int i = 0; i < 50; i++) send_bit(1'b0, 0);
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 8; i++) send_bit(faw_v[7-i], 0);
      for (int i = 8; i < FLEN; i++) send_bit(1'b0, 0);
    end
    check("t4_rise_acc", rise_acc, 808);
    check("t4_rise_pos", rise_pos, 8);

    // Random in_en gaps: same lock point counted in accepted bits.
    pulse_reset();
    clear_counts();
    repeat (4) send_frame(TB_FAW, 30);
    check("t5_rise_acc", rise_acc, 408);
    check("t5_idle_pulses", idle_pulses, 0);
    check("t5_in_sync", int'(in_sync), 1);

    // One-cycle reset mid-SYNC, then relock.
    pulse_reset();
    check_all_zero("t6");
    clear_counts();
    repeat (3) send_frame(TB_FAW, 0);
    check("t6_rise_acc", rise_acc, 408);

    din_en = 1'b0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
